mem_stage_lat: RTL and testbench

Parametrised Y86-64 memory-access pipeline stage: the M-stage pipeline register plus a byte-addressed data memory with configurable depth and access latency. Performs 8-byte little-endian loads and stores for rmmovq, mrmovq, pushq, popq, call and ret. Forwards execute-stage results to write-back. Holds the upstream pipeline with `busy_o` while a multi-cycle access is in flight.

---
 rtl/mem_stage_lat.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage_lat.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lat.sv
// Y86-64 M-stage pipeline register with byte-addressed data memory and configurable access latency.
// Optional bounds/alignment fault checking is enabled by defining DMEM_ADDR_CHECK_EN.
module mem_stage_lat #(
   parameter int DMEM_BYTES = 1024,
   parameter int MEM_LAT    = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        bubble_i,
   input  logic [3:0]  icode_i,
   input  logic [2:0]  stat_i,
   input  logic [63:0] valA_i,
   input  logic [63:0] valE_i,
   input  logic [3:0]  dstE_i,
   input  logic [3:0]  dstM_i,
   input  logic        cnd_i,
   output logic [3:0]  icode_o,
   output logic [2:0]  stat_o,
   output logic [3:0]  dstE_o,
   output logic [3:0]  dstM_o,
   output logic [63:0] valE_o,
   output logic [63:0] M_valA_o,
   output logic [63:0] valM_o,
   output logic        busy_o,
   output logic        mem_err_o
);

   localparam int AW = $clog2(DMEM_BYTES);

   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [3:0] RNONE   = 4'hF;

   localparam logic [2:0] STAT_BUBBLE = 3'd0;
   localparam logic [2:0] STAT_OK     = 3'd1;
   localparam logic [2:0] STAT_ADR    = 3'd3;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   function automatic logic isRead(input logic [3:0] ic);
      return (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
   endfunction

   function automatic logic isWrite(input logic [3:0] ic);
      return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
   endfunction

   function automatic logic [63:0] selAddr(input logic [3:0] ic, input logic [63:0] va,
                                           input logic [63:0] ve);
      return ((ic == IRET) || (ic == IPOPQ)) ? va : ve;
   endfunction

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [3:0]  r_icode;
   logic [2:0]  r_stat;
   logic [3:0]  r_dstE;
   logic [3:0]  r_dstM;
   logic [63:0] r_valE;
   logic [63:0] r_valA;
   logic [63:0] r_valM;
   logic        r_cnd;
   logic        r_busy;
   logic        r_memErr;
   logic [7:0]  r_mem [DMEM_BYTES];

   logic [63:0]   w_inAddr;
   logic [63:0]   w_regAddr;
   logic          w_inMem;
   logic          w_accept;
   logic          w_fault;
   logic          w_waitDone;
   logic          w_doAccess;
   logic [3:0]    w_accIcode;
   logic [63:0]   w_accAddr;
   logic [63:0]   w_accData;
   logic [AW-1:0] w_accIdx;
   logic          w_wrEn;
   logic          w_rdEn;
   logic [63:0]   w_rdData;
   logic          w_unused;

   // A single access port: either the accept edge (MEM_LAT==1) or the last WAIT edge, using the held instruction.
   always_comb begin
      w_inAddr   = selAddr(icode_i, valA_i, valE_i);
      w_regAddr  = selAddr(r_icode, r_valA, r_valE);
      w_inMem    = (isRead(icode_i) || isWrite(icode_i)) && (stat_i == STAT_OK);
      w_accept   = !rst_i && (r_state == ST_IDLE) && !stall_i && !bubble_i;
`ifdef DMEM_ADDR_CHECK_EN
      w_fault    = w_accept && w_inMem &&
                   ((({1'b0, w_inAddr} + 65'd7) >= 65'(DMEM_BYTES)) ||
                    (w_inAddr[2:0] != 3'b000) ||
                    (w_inAddr[63:AW] != '0));
`else
      w_fault    = 1'b0;
`endif
      w_waitDone = !rst_i && (r_state == ST_WAIT) && (r_cnt == 4'd1);
      w_doAccess = w_waitDone || (w_accept && w_inMem && !w_fault && (MEM_LAT == 1));
      w_accIcode = w_waitDone ? r_icode : icode_i;
      w_accAddr  = w_waitDone ? w_regAddr : w_inAddr;
      w_accData  = w_waitDone ? r_valA : valA_i;
      w_accIdx   = w_accAddr[AW-1:0];
      w_wrEn     = w_doAccess && isWrite(w_accIcode);
      w_rdEn     = w_doAccess && isRead(w_accIcode);
      w_rdData   = '0;
      for (int k = 0; k < 8; k++) begin
         w_rdData[8*k +: 8] = r_mem[w_accIdx + AW'(k)];
      end
   end

   // Byte index arithmetic is AW bits wide, so multi-byte accesses wrap inside the memory.
   always_ff @(posedge clk_i) begin
      if (w_wrEn) begin
         for (int k = 0; k < 8; k++) begin
            r_mem[w_accIdx + AW'(k)] <= w_accData[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_icode  <= INOP;
         r_stat   <= STAT_BUBBLE;
         r_dstE   <= RNONE;
         r_dstM   <= RNONE;
         r_valE   <= '0;
         r_valA   <= '0;
         r_valM   <= '0;
         r_cnd    <= 1'b0;
         r_busy   <= 1'b0;
         r_memErr <= 1'b0;
      end else if (r_state == ST_WAIT) begin
         r_memErr <= 1'b0;
         r_cnt    <= r_cnt - 4'd1;
         if (r_cnt == 4'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (w_rdEn) r_valM <= w_rdData;
         end
      end else if (stall_i) begin
         // The fault flag is a one-cycle pulse even if the stage is then stalled.
         r_memErr <= 1'b0;
      end else if (bubble_i) begin
         r_icode  <= INOP;
         r_stat   <= STAT_BUBBLE;
         r_dstE   <= RNONE;
         r_dstM   <= RNONE;
         r_valE   <= '0;
         r_valA   <= '0;
         r_cnd    <= 1'b0;
         r_memErr <= 1'b0;
      end else begin
         r_icode  <= icode_i;
         r_stat   <= w_fault ? STAT_ADR : stat_i;
         r_dstE   <= dstE_i;
         r_dstM   <= dstM_i;
         r_valE   <= valE_i;
         r_valA   <= valA_i;
         r_cnd    <= cnd_i;
         r_memErr <= w_fault;
         if (w_fault) begin
            r_valM <= '0;
         end else if (w_rdEn) begin
            r_valM <= w_rdData;
         end
         if (w_inMem && !w_fault && (MEM_LAT > 1)) begin
            r_state <= ST_WAIT;
            r_cnt   <= 4'(MEM_LAT - 1);
            r_busy  <= 1'b1;
         end
      end
   end

   assign w_unused = ^{r_cnd, w_inAddr, w_regAddr};

   assign icode_o   = r_icode;
   assign stat_o    = r_stat;
   assign dstE_o    = r_dstE;
   assign dstM_o    = r_dstM;
   assign valE_o    = r_valE;
   assign M_valA_o  = r_valA;
   assign valM_o    = r_valM;
   assign busy_o    = r_busy;
   assign mem_err_o = r_memErr;

endmodule

// File: tb/tb_mem_stage_lat.sv
// Directed bench for mem_stage_lat: three instances with MEM_LAT of 1, 3 and 4 over a 1 KiB memory.
// Fault-checking scenarios compile in when DMEM_ADDR_CHECK_EN is defined, wrap scenarios otherwise.
module tb_mem_stage_lat;

   localparam logic [3:0] INOP = 4'h1, IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6;
   localparam logic [3:0] IPUSHQ = 4'hA, IPOPQ = 4'hB, RNONE = 4'hF;
   localparam logic [2:0] SBUB = 3'd0, SAOK = 3'd1, SHLT = 3'd2;
`ifdef DMEM_ADDR_CHECK_EN
   localparam logic [2:0] SADR = 3'd3;
`endif

   logic        clk;
   logic        rst [3];
   logic        stall [3];
   logic        bubble [3];
   logic        cnd [3];
   logic [3:0]  icode [3];
   logic [3:0]  dstE [3];
   logic [3:0]  dstM [3];
   logic [2:0]  stat [3];
   logic [63:0] valA [3];
   logic [63:0] valE [3];
   logic [3:0]  icodeO [3];
   logic [3:0]  dstEO [3];
   logic [3:0]  dstMO [3];
   logic [2:0]  statO [3];
   logic [63:0] valEO [3];
   logic [63:0] valAO [3];
   logic [63:0] valMO [3];
   logic        busyO [3];
   logic        memErrO [3];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < 3; g++) begin : gDut
      mem_stage_lat #(
         .DMEM_BYTES(1024),
         .MEM_LAT   ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .clk_i    (clk),
         .rst_i    (rst[g]),
         .stall_i  (stall[g]),
         .bubble_i (bubble[g]),
         .icode_i  (icode[g]),
         .stat_i   (stat[g]),
         .valA_i   (valA[g]),
         .valE_i   (valE[g]),
         .dstE_i   (dstE[g]),
         .dstM_i   (dstM[g]),
         .cnd_i    (cnd[g]),
         .icode_o  (icodeO[g]),
         .stat_o   (statO[g]),
         .dstE_o   (dstEO[g]),
         .dstM_o   (dstMO[g]),
         .valE_o   (valEO[g]),
         .M_valA_o (valAO[g]),
         .valM_o   (valMO[g]),
         .busy_o   (busyO[g]),
         .mem_err_o(memErrO[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int d, input logic [3:0] ic, input logic [2:0] st,
                                input logic [63:0] ve, input logic [63:0] va,
                                input logic [3:0] de, input logic [3:0] dm);
      icode[d]  = ic;
      stat[d]   = st;
      valE[d]   = ve;
      valA[d]   = va;
      dstE[d]   = de;
      dstM[d]   = dm;
      stall[d]  = 1'b0;
      bubble[d] = 1'b0;
   endtask

   task automatic idle(input int d);
      applyStimulus(d, INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE);
   endtask

   task automatic waitIdle(input int d, output int n);
      n = 0;
      while (busyO[d] === 1'b1 && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         idle(d);
         cnd[d] = 1'b0;
         rst[d] = 1'b1;
      end
      step();
      step();
      checks++; if (icodeO[0] !== INOP) begin errors++; $display("[TB] FAIL reset_icode: got %h expected %h", icodeO[0], INOP); end
      checks++; if (statO[0] !== SBUB) begin errors++; $display("[TB] FAIL reset_stat: got %h expected %h", statO[0], SBUB); end
      checks++; if (dstEO[0] !== RNONE || dstMO[0] !== RNONE) begin errors++; $display("[TB] FAIL reset_dst: got %h/%h expected f/f", dstEO[0], dstMO[0]); end
      checks++; if ({valEO[0], valAO[0], valMO[0]} !== 192'd0) begin errors++; $display("[TB] FAIL reset_vals: got %h %h %h expected 0", valEO[0], valAO[0], valMO[0]); end
      checks++; if (busyO[2] !== 1'b0 || memErrO[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got busy=%b err=%b expected 0/0", busyO[2], memErrO[0]); end
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      step();
   endtask

   task automatic test_store_load();
      applyStimulus(0, IRMMOVQ, SAOK, 64'h10, 64'h1122334455667788, RNONE, RNONE);
      step();
      checks++; if (icodeO[0] !== IRMMOVQ || valAO[0] !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL store_regs: got %h %h expected 4 1122334455667788", icodeO[0], valAO[0]); end
      applyStimulus(0, IMRMOVQ, SAOK, 64'h10, 64'd0, RNONE, 4'h3);
      step();
      checks++; if (valMO[0] !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL load_raw: got %h expected 1122334455667788", valMO[0]); end
      checks++; if (dstMO[0] !== 4'h3) begin errors++; $display("[TB] FAIL load_dstM: got %h expected 3", dstMO[0]); end
      idle(0);
      step();
      checks++; if (valMO[0] !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL nop_keeps_valM: got %h expected 1122334455667788", valMO[0]); end
   endtask

   task automatic test_bubble_stall();
      applyStimulus(0, IOPQ, SAOK, 64'h5, 64'h5, 4'h2, RNONE);
      bubble[0] = 1'b1;
      step();
      checks++; if (icodeO[0] !== INOP || statO[0] !== SBUB) begin errors++; $display("[TB] FAIL bubble_icode_stat: got %h/%h expected 1/0", icodeO[0], statO[0]); end
      checks++; if (dstEO[0] !== RNONE || valEO[0] !== 64'd0) begin errors++; $display("[TB] FAIL bubble_dst_val: got %h/%h expected f/0", dstEO[0], valEO[0]); end
      applyStimulus(0, IMRMOVQ, SAOK, 64'h18, 64'h7, 4'h2, 4'h3);
      stall[0] = 1'b1;
      step();
      step();
      checks++; if (icodeO[0] !== INOP || statO[0] !== SBUB || dstMO[0] !== RNONE) begin errors++; $display("[TB] FAIL stall_hold: got %h/%h/%h expected 1/0/f", icodeO[0], statO[0], dstMO[0]); end
      checks++; if (valMO[0] !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL stall_valM: got %h expected 1122334455667788", valMO[0]); end
      idle(0);
      step();
   endtask

   task automatic test_suppressed();
      applyStimulus(0, IRMMOVQ, SAOK, 64'h20, 64'hCAFE, RNONE, RNONE);
      step();
      applyStimulus(0, IRMMOVQ, SHLT, 64'h20, 64'hDEAD, RNONE, RNONE);
      step();
      checks++; if (statO[0] !== SHLT) begin errors++; $display("[TB] FAIL suppress_stat: got %h expected %h", statO[0], SHLT); end
      applyStimulus(0, IMRMOVQ, SAOK, 64'h20, 64'd0, RNONE, 4'h1);
      step();
      checks++; if (valMO[0] !== 64'hCAFE) begin errors++; $display("[TB] FAIL suppress_mem: got %h expected cafe", valMO[0]); end
      idle(0);
      step();
   endtask

`ifdef DMEM_ADDR_CHECK_EN
   task automatic test_addr_fault();
      applyStimulus(0, IRMMOVQ, SAOK, 64'h3F8, 64'h77, RNONE, RNONE);
      step();
      applyStimulus(0, IMRMOVQ, SAOK, 64'h3FC, 64'd0, RNONE, 4'h3);
      step();
      checks++; if (statO[0] !== SADR || memErrO[0] !== 1'b1) begin errors++; $display("[TB] FAIL fault_load_flags: got stat=%h err=%b expected 3/1", statO[0], memErrO[0]); end
      checks++; if (valMO[0] !== 64'd0) begin errors++; $display("[TB] FAIL fault_load_valM: got %h expected 0", valMO[0]); end
      idle(0);
      step();
      checks++; if (memErrO[0] !== 1'b0) begin errors++; $display("[TB] FAIL fault_pulse_len: got %b expected 0", memErrO[0]); end
      applyStimulus(0, IRMMOVQ, SAOK, 64'h401, 64'hFFFFFFFFFFFFFFFF, RNONE, RNONE);
      step();
      checks++; if (statO[0] !== SADR) begin errors++; $display("[TB] FAIL fault_store_stat: got %h expected 3", statO[0]); end
      applyStimulus(0, IMRMOVQ, SAOK, 64'h3F8, 64'd0, RNONE, 4'h3);
      step();
      checks++; if (valMO[0] !== 64'h77 || statO[0] !== SAOK) begin errors++; $display("[TB] FAIL fault_no_write: got %h stat=%h expected 77 stat=1", valMO[0], statO[0]); end
      idle(0);
      step();
   endtask
`else
   task automatic test_wrap();
      applyStimulus(0, IRMMOVQ, SAOK, 64'h3FC, 64'h8877665544332211, RNONE, RNONE);
      step();
      checks++; if (statO[0] !== SAOK || memErrO[0] !== 1'b0) begin errors++; $display("[TB] FAIL wrap_store_flags: got stat=%h err=%b expected 1/0", statO[0], memErrO[0]); end
      applyStimulus(0, IMRMOVQ, SAOK, 64'h7FC, 64'd0, RNONE, 4'h3);
      step();
      checks++; if (valMO[0] !== 64'h8877665544332211) begin errors++; $display("[TB] FAIL wrap_load: got %h expected 8877665544332211", valMO[0]); end
      idle(0);
      step();
   endtask
`endif

   task automatic test_push_pop();
      applyStimulus(1, IPUSHQ, SAOK, 64'h3F8, 64'hAB, 4'h4, RNONE);
      step();
      checks++; if (busyO[1] !== 1'b1) begin errors++; $display("[TB] FAIL push_busy1: got %b expected 1", busyO[1]); end
      applyStimulus(1, IOPQ, SAOK, 64'h55, 64'h66, 4'h2, 4'h2);
      bubble[1] = 1'b1;
      step();
      checks++; if (busyO[1] !== 1'b1) begin errors++; $display("[TB] FAIL push_busy2: got %b expected 1", busyO[1]); end
      step();
      checks++; if (busyO[1] !== 1'b0) begin errors++; $display("[TB] FAIL push_busy_end: got %b expected 0", busyO[1]); end
      checks++; if (icodeO[1] !== IPUSHQ || dstEO[1] !== 4'h4 || valEO[1] !== 64'h3F8) begin errors++; $display("[TB] FAIL push_hold: got %h/%h/%h expected a/4/3f8", icodeO[1], dstEO[1], valEO[1]); end
      applyStimulus(1, IPOPQ, SAOK, 64'h400, 64'h3F8, 4'h4, 4'h5);
      step();
      checks++; if (busyO[1] !== 1'b1) begin errors++; $display("[TB] FAIL pop_busy1: got %b expected 1", busyO[1]); end
      idle(1);
      step();
      checks++; if (busyO[1] !== 1'b1 || valMO[1] !== 64'd0) begin errors++; $display("[TB] FAIL pop_early: got busy=%b valM=%h expected 1/0", busyO[1], valMO[1]); end
      step();
      checks++; if (busyO[1] !== 1'b0 || valMO[1] !== 64'hAB) begin errors++; $display("[TB] FAIL pop_valM: got busy=%b valM=%h expected 0/ab", busyO[1], valMO[1]); end
      step();
   endtask

   task automatic test_reset_wait();
      int n;
      applyStimulus(2, IRMMOVQ, SAOK, 64'h40, 64'h5555, RNONE, RNONE);
      step();
      idle(2);
      waitIdle(2, n);
      checks++; if (n !== 3) begin errors++; $display("[TB] FAIL lat4_busy_len: got %0d expected 3", n); end
      applyStimulus(2, IRMMOVQ, SAOK, 64'h40, 64'h9999, RNONE, RNONE);
      step();
      idle(2);
      step();
      rst[2] = 1'b1;
      step();
      checks++; if (busyO[2] !== 1'b0 || statO[2] !== SBUB || icodeO[2] !== INOP) begin errors++; $display("[TB] FAIL wait_reset: got busy=%b stat=%h icode=%h expected 0/0/1", busyO[2], statO[2], icodeO[2]); end
      rst[2] = 1'b0;
      applyStimulus(2, IMRMOVQ, SAOK, 64'h40, 64'd0, RNONE, 4'h6);
      step();
      idle(2);
      waitIdle(2, n);
      checks++; if (n !== 3) begin errors++; $display("[TB] FAIL lat4_load_len: got %0d expected 3", n); end
      checks++; if (valMO[2] !== 64'h5555) begin errors++; $display("[TB] FAIL wait_abort_mem: got %h expected 5555", valMO[2]); end
   endtask

   task automatic checkOutput();
      $display("Result: errors=%0d of %0d checks", errors, checks);
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_bubble_stall();
      test_suppressed();
`ifdef DMEM_ADDR_CHECK_EN
      test_addr_fault();
`else
      test_wrap();
`endif
      test_push_pop();
      test_reset_wait();
      checkOutput();
      $finish;
   end

endmodule
